// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath and memory port.
// The controller side is the master; the datapath/memory side is the slave.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       lt;
  logic       ltu;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [3:0] alu_control;
  logic [2:0] imm_src;
  logic       illegal;
  logic       retire;
  logic [3:0] state_o;

  // Memory handshake: a request is open while mem_req=1. It completes on the
  // first rising edge where mem_ready=1 is sampled. Until then the address
  // select and mem_write hold steady. mem_ready is ignored while mem_req=0.
  modport master (
    input  opcode, funct3, funct7b5, zero, lt, ltu, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
    output alu_src_a, alu_src_b, result_src, alu_control, imm_src,
    output illegal, retire, state_o
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, lt, ltu, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
    input  alu_src_a, alu_src_b, result_src, alu_control, imm_src,
    input  illegal, retire, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: fetch, decode, execute,
// memory and writeback. Outputs are Moore, except the mem_ready and branch-flag qualified strobes.
module multicycle_ctrl (
  input  logic             clk,
  input  logic             reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  state_t     r_state;
  state_t     w_next_state;
  logic       w_mem_req;
  logic       w_mem_write;
  logic       w_adr_src;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_reg_write;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_result_src;
  logic [3:0] w_alu_control;
  logic [2:0] w_imm_src;
  logic       w_illegal;
  logic       w_retire;
  logic [3:0] w_func_op;
  logic       w_taken;
  logic       w_is_store;

  assign w_is_store = bus.opcode[5];

  // funct7b5 selects sub only for register ops; for immediates bit 30 is imm data.
  always_comb begin
    w_func_op = ALU_ADD;
    case (bus.funct3)
      3'b000:  w_func_op = (bus.funct7b5 && r_state == S_EXECR) ? ALU_SUB : ALU_ADD;
      3'b001:  w_func_op = ALU_SLL;
      3'b010:  w_func_op = ALU_SLT;
      3'b011:  w_func_op = ALU_SLTU;
      3'b100:  w_func_op = ALU_XOR;
      3'b101:  w_func_op = bus.funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_func_op = ALU_OR;
      default: w_func_op = ALU_AND;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (bus.funct3)
      3'b000:  w_taken = bus.zero;
      3'b001:  w_taken = ~bus.zero;
      3'b100:  w_taken = bus.lt;
      3'b101:  w_taken = ~bus.lt;
      3'b110:  w_taken = bus.ltu;
      3'b111:  w_taken = ~bus.ltu;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:    if (bus.mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        if ((bus.opcode == 7'b0000011 || bus.opcode == 7'b0100011) && bus.funct3 == 3'b010)
          w_next_state = S_MEMADR;
        else if (bus.opcode == 7'b0110011)
          w_next_state = S_EXECR;
        else if (bus.opcode == 7'b0010011)
          w_next_state = S_EXECI;
        else if (bus.opcode == 7'b1100011 && bus.funct3[2:1] != 2'b01)
          w_next_state = S_BRANCH;
        else
          w_next_state = S_ILLEGAL;
      end
      S_MEMADR:   w_next_state = w_is_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) w_next_state = S_MEMWB;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) w_next_state = S_FETCH;
      S_EXECR:    w_next_state = S_ALUWB;
      S_EXECI:    w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      S_ILLEGAL:  w_next_state = S_ILLEGAL;
      default:    w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    w_mem_req     = 1'b0;
    w_mem_write   = 1'b0;
    w_adr_src     = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_src_a   = 2'b00;
    w_alu_src_b   = 2'b00;
    w_result_src  = 2'b00;
    w_alu_control = ALU_ADD;
    w_imm_src     = 3'b000;
    w_illegal     = 1'b0;
    w_retire      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        w_imm_src   = 3'b011;
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_imm_src   = w_is_store ? 3'b010 : 3'b001;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        w_retire    = bus.mem_ready;
      end
      S_EXECR: begin
        w_alu_src_a   = 2'b10;
        w_alu_control = w_func_op;
      end
      S_EXECI: begin
        w_alu_src_a   = 2'b10;
        w_alu_src_b   = 2'b01;
        w_imm_src     = 3'b001;
        w_alu_control = w_func_op;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a   = 2'b10;
        w_alu_control = ALU_SUB;
        w_pc_write    = w_taken;
        w_retire      = 1'b1;
      end
      S_ILLEGAL:  w_illegal = 1'b1;
      default: ;
    endcase
  end

  // Enables are gated by reset directly so an abort takes effect before any edge.
  assign bus.mem_req     = w_mem_req   & ~reset;
  assign bus.mem_write   = w_mem_write & ~reset;
  assign bus.ir_write    = w_ir_write  & ~reset;
  assign bus.pc_write    = w_pc_write  & ~reset;
  assign bus.reg_write   = w_reg_write & ~reset;
  assign bus.retire      = w_retire    & ~reset;
  assign bus.illegal     = w_illegal   & ~reset;
  assign bus.adr_src     = w_adr_src;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.result_src  = w_result_src;
  assign bus.alu_control = w_alu_control;
  assign bus.imm_src     = w_imm_src;
  assign bus.state_o     = r_state;

endmodule
